// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// legal operand width bounds.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_bit_slice.sv
// Combinational 1-bit full adder built from two half adders and an OR.
module fa_bit_slice (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic p;
  logic g_ab;
  logic g_pc;

  always_comb begin
    p     = a ^ b;
    g_ab  = a & b;
    sum   = p ^ c;
    g_pc  = p & c;
    carry = g_ab | g_pc;
  end

endmodule : fa_bit_slice

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are latched on start and fed LSB-first through
// one full-adder slice, one bit per clock; result is held until the next one.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output state_e           state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Handshake: start is a request that is only honoured while IDLE; done is
  // a one-cycle qualifier for sum_out/cout_out, which otherwise just hold.
  state_e           state_q,    state_d;
  logic [WIDTH-1:0] a_sr_q,     a_sr_d;
  logic [WIDTH-1:0] b_sr_q,     b_sr_d;
  logic [WIDTH-1:0] sum_sr_q,   sum_sr_d;
  logic             carry_q,    carry_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [WIDTH-1:0] sum_out_q,  sum_out_d;
  logic             cout_out_q, cout_out_d;

  logic slice_sum;
  logic slice_carry;

  fa_bit_slice u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c     (carry_q),
    .sum   (slice_sum),
    .carry (slice_carry)
  );

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    sum_sr_d   = sum_sr_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sum_out_d  = sum_out_q;
    cout_out_d = cout_out_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a_in;
          b_sr_d   = b_in;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        sum_sr_d = {slice_sum, sum_sr_q[WIDTH-1:1]};
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d  = slice_carry;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Publish straight from the slice so the result is already valid
          // in the DONE cycle, not one cycle later.
          sum_out_d  = {slice_sum, sum_sr_q[WIDTH-1:1]};
          cout_out_d = slice_carry;
          state_d    = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      sum_sr_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sum_out_q  <= '0;
      cout_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      sum_sr_q   <= sum_sr_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      sum_out_q  <= sum_out_d;
      cout_out_q <= cout_out_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sum_out   = sum_out_q;
  assign cout_out  = cout_out_q;
  assign state_dbg = state_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=13: vector table,
// hand-written corner sequences and random operands against an arithmetic model.
module tb_serial_adder;
  import serial_adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- DUT signals ----------------
  logic [31:0] a_bus = '0;
  logic [31:0] b_bus = '0;
  logic        cin_s = 1'b0;
  logic        start8 = 1'b0;
  logic        start13 = 1'b0;

  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  state_e      st8;
  logic        busy13, done13, cout13;
  logic [12:0] sum13;
  state_e      st13;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a_in(a_bus[7:0]), .b_in(b_bus[7:0]), .cin(cin_s),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8),
    .state_dbg(st8)
  );

  serial_adder #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13),
    .a_in(a_bus[12:0]), .b_in(b_bus[12:0]), .cin(cin_s),
    .busy(busy13), .done(done13), .sum_out(sum13), .cout_out(cout13),
    .state_dbg(st13)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];
  logic [32:0] last_res[2];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done13;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy13;
  endfunction

  function automatic logic [32:0] get_res(input int w);
    return (w == 8) ? {24'b0, cout8, sum8} : {19'b0, cout13, sum13};
  endfunction

  // Reference: plain unsigned addition at WIDTH+1 bits.
  function automatic logic [32:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic c);
    logic [32:0] mask;
    mask = (33'd1 << w) - 33'd1;
    return (33'(a) & mask) + (33'(b) & mask) + 33'(c);
  endfunction

  // ---------------- done monitors ----------------
  int done8_cnt = 0;
  int done13_cnt = 0;
  int last_done8 = -1;
  int last_done13 = -1;

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      done8_cnt++;
      if (last_done8 >= 0) check("done_spacing_w8", 33'(cyc_cnt - last_done8 >= 10), 33'd1);
      last_done8 = cyc_cnt;
    end
    if (done13 === 1'b1) begin
      done13_cnt++;
      if (last_done13 >= 0) check("done_spacing_w13", 33'(cyc_cnt - last_done13 >= 15), 33'd1);
      last_done13 = cyc_cnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 8) start8 = v;
    else start13 = v;
  endtask

  // Wait (bounded) for done on the selected instance; returns cycles waited.
  task automatic wait_done(input int w, input bit spurious, output int cycles, output bit seen);
    cycles = 0;
    seen = 0;
    while (!seen && cycles < w + 4) begin
      if (spurious) begin
        a_bus = $urandom;
        b_bus = $urandom;
        cin_s = 1'($urandom_range(0, 1));
        set_start(w, 1'($urandom_range(0, 1)));
      end
      tick();
      cycles++;
      if (get_done(w) === 1'b1) seen = 1;
    end
    set_start(w, 1'b0);
  endtask

  // One operation from IDLE; leaves the DUT back in IDLE.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic [32:0] exp, input bit spurious);
    int cycles;
    bit seen;
    int idx;
    logic [32:0] e;
    idx = (w == 8) ? 0 : 1;
    a_bus = a;
    b_bus = b;
    cin_s = c;
    set_start(w, 1'b1);
    exp_q.push_back(exp);
    tick();
    set_start(w, 1'b0);
    check("busy_after_start", 33'(get_busy(w)), 33'd1);
    check("hold_during_shift", get_res(w), last_res[idx]);
    wait_done(w, spurious, cycles, seen);
    check("done_latency", 33'(cycles), 33'(w));
    e = exp_q.pop_front();
    if (seen) begin
      check("result", get_res(w), e);
      last_res[idx] = e;
    end
    tick();
    check("done_one_cycle", 33'(get_done(w)), 33'd0);
    check("idle_after_done", 33'(get_busy(w)), 33'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cycles;
    bit seen;
    int d_before;
    logic [31:0] ra, rb;
    logic rc;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h3C, 8'hA5, 1'b0, 8'hE1, 1'b0};
    vecs[4] = '{8'h11, 8'h22, 1'b1, 8'h34, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[7] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    last_res[0] = '0;
    last_res[1] = '0;

    // Reset held for two cycles with start asserted: nothing may start.
    rst_n = 1'b0;
    start8 = 1'b1;
    start13 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_busy8", 33'(busy8), 33'd0);
      check("rst_done8", 33'(done8), 33'd0);
      check("rst_res8", get_res(8), 33'd0);
      check("rst_busy13", 33'(busy13), 33'd0);
      check("rst_res13", get_res(13), 33'd0);
    end
    start8 = 1'b0;
    start13 = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_state8", 33'(st8), 33'(IDLE));
    check("idle_busy8", 33'(busy8), 33'd0);

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++)
      do_op(8, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin,
            {24'b0, vecs[i].exp_cout, vecs[i].exp_sum}, 1'b0);

    // start while busy is ignored; then back-to-back start right after done.
    d_before = done8_cnt;
    a_bus = 32'h3C; b_bus = 32'hA5; cin_s = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    a_bus = 32'h11; b_bus = 32'h22; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done(8, 1'b0, cycles, seen);
    check("busy_ignore_seen", 33'(seen), 33'd1);
    check("busy_ignore_res", get_res(8), 33'h0E1);
    last_res[0] = 33'h0E1;
    tick();
    do_op(8, 32'h11, 32'h22, 1'b1, 33'h034, 1'b0);
    check("busy_ignore_done_cnt", 33'(done8_cnt - d_before), 33'd2);

    // Reset in the middle of an operation aborts it.
    do_op(8, 32'h3C, 32'hA5, 1'b0, 33'h0E1, 1'b0);
    check("prior_held", get_res(8), 33'h0E1);
    d_before = done8_cnt;
    a_bus = 32'h80; b_bus = 32'h80; cin_s = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", 33'(busy8), 33'd0);
    check("abort_res", get_res(8), 33'd0);
    check("abort_done", 33'(done8), 33'd0);
    last_res[0] = '0;
    last_res[1] = '0;
    for (int i = 0; i < 12; i++) tick();
    check("abort_no_done", 33'(done8_cnt - d_before), 33'd0);
    do_op(8, 32'h80, 32'h80, 1'b0, 33'h100, 1'b0);

    // Randomised operands, with noise on start/operands while busy.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      do_op(8, ra, rb, rc, model(8, ra, rb, rc), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      do_op(13, ra, rb, rc, model(13, ra, rb, rc), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    // Boundary at WIDTH=13: all-ones ripple.
    do_op(13, 32'h1FFF, 32'h0001, 1'b0, 33'h2000, 1'b0);
    do_op(13, 32'h1FFF, 32'h1FFF, 1'b1, 33'h3FFF, 1'b0);

    check("scoreboard_empty", 33'(exp_q.size()), 33'd0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_serial_adder
